uart_byte_rx: RTL and testbench

//  Receiving end of the 8N1 UART link driven by uart_byte_tx. Oversamples the

---
 rtl/uart_byte_rx_pkg.sv | 33 +++
 rtl/uart_byte_rx_baud_tick.sv | 59 +++++
 rtl/uart_byte_rx.sv | 131 +++++++++++++
 tb/tb_uart_byte_rx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver.
//   - baud code constants carried on baud_set
//   - baud divider function: the tick divider reload value for a clock/baud pair
//   - receiver FSM state encoding
//   - 2-of-3 majority helper used by the bit vote
package uart_byte_rx_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Width of the oversample tick divider counter.
    localparam int DIV_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Divider reload: one tick every (DIV + 1) clocks gives 16 ticks per bit.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input int baud);
        return DIV_W'(clk_freq / (baud * 16) - 1);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_rx_baud_tick.sv
// Oversample tick generator for the UART receiver.
// Latches the baud code when a frame starts and produces a one-cycle tick every
// DIV+1 clocks while the receiver is busy.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   baud_set  in   baud code, sampled only on restart
//   restart   in   start-edge detect: latch baud_set, clear the divider
//   run       in   divider counts only while high (receiver outside IDLE)
//   tick      out  one-cycle oversample tick
module uart_baud_tick
    import uart_byte_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_set,
    input  logic       restart,
    input  logic       run,
    output logic       tick
);

    localparam logic [DIV_W-1:0] DIV_9600   = baud_div(CLK_FREQ, 9600);
    localparam logic [DIV_W-1:0] DIV_19200  = baud_div(CLK_FREQ, 19200);
    localparam logic [DIV_W-1:0] DIV_38400  = baud_div(CLK_FREQ, 38400);
    localparam logic [DIV_W-1:0] DIV_57600  = baud_div(CLK_FREQ, 57600);
    localparam logic [DIV_W-1:0] DIV_115200 = baud_div(CLK_FREQ, 115200);

    logic [2:0]       baud_lat;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;

    // Codes 5..7 fall back to 9600.
    always_comb begin
        case (baud_lat)
            BAUD_19200:  div = DIV_19200;
            BAUD_38400:  div = DIV_38400;
            BAUD_57600:  div = DIV_57600;
            BAUD_115200: div = DIV_115200;
            default:     div = DIV_9600;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_lat <= BAUD_9600;
            cnt      <= '0;
        end else if (restart) begin
            baud_lat <= baud_set;
            cnt      <= '0;
        end else if (run) begin
            cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
        end
    end

    assign tick = run && (cnt == div);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and 2-of-3 majority vote.
// Ports:
//   clk         in   system clock, all state on rising edge
//   reset       in   asynchronous, active-high reset
//   baud_set    in   0:9600 1:19200 2:38400 3:57600 4:115200 5-7:9600
//   uart_rx     in   serial line, idle high, asynchronous to clk
//   data_byte   out  last received byte, held until the next frame completes
//   rx_done     out  one-cycle strobe, data_byte valid in the same cycle
//   frame_err   out  one-cycle strobe with rx_done when the stop bit votes low
//   uart_state  out  high while a frame is in progress
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_set,
    input  logic       uart_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] VOTE_A    = 4'd6;
    localparam logic [3:0] VOTE_B    = 4'd7;
    localparam logic [3:0] VOTE_C    = 4'd8;

    logic       meta;
    logic [1:0] sync;       // sync[0] newest synchronized sample, sync[1] one cycle older
    logic [2:0] prime;      // fills with ones once the synchronizer holds real line data
    rx_state_t  state;
    rx_state_t  state_next;
    logic       tick;
    logic       fall;
    logic       run;
    logic       restart;
    logic       bit_end;
    logic       vote_point;
    logic       voted;
    logic [3:0] bit_cnt;
    logic [2:0] bit_idx;
    logic [1:0] vote_smp;
    logic [7:0] shift;

    // Synchronizer. The flops reset to the idle level; the prime shifter keeps
    // a line that is already low at reset release from looking like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b1;
            sync  <= 2'b11;
            prime <= 3'b000;
        end else begin
            meta  <= uart_rx;
            sync  <= {sync[0], meta};
            prime <= {prime[1:0], 1'b1};
        end
    end

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud_tick (
        .clk      (clk),
        .reset    (reset),
        .baud_set (baud_set),
        .restart  (restart),
        .run      (run),
        .tick     (tick)
    );

    always_comb begin
        fall       = prime[2] & sync[1] & ~sync[0];
        run        = (state != ST_IDLE);
        restart    = (state == ST_IDLE) && fall;
        bit_end    = tick && (bit_cnt == LAST_TICK);
        vote_point = tick && (bit_cnt == VOTE_C);
        voted      = maj3(vote_smp[0], vote_smp[1], sync[0]);
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fall) state_next = ST_START;
            end
            ST_START: begin
                // A start bit that votes high was a glitch.
                if (vote_point && voted)  state_next = ST_IDLE;
                else if (bit_end)         state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Leave mid stop bit so a following start edge is never missed.
                if (vote_point) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign uart_state = run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            data_byte <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) bit_cnt <= '0;
            else if (tick)           bit_cnt <= bit_cnt + 4'd1;
            if (state != ST_DATA)    bit_idx <= '0;
            else if (bit_end)        bit_idx <= bit_idx + 3'd1;
            rx_done   <= (state == ST_STOP) && vote_point;
            frame_err <= (state == ST_STOP) && vote_point && !voted;
            if ((state == ST_STOP) && vote_point) data_byte <= shift;
        end
    end

    // Vote samples and the data shifter carry no control meaning, so no reset.
    always_ff @(posedge clk) begin
        if (tick && (bit_cnt == VOTE_A)) vote_smp[0] <= sync[0];
        if (tick && (bit_cnt == VOTE_B)) vote_smp[1] <= sync[0];
        if ((state == ST_DATA) && vote_point) shift[bit_idx] <= voted;
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: serial frames are generated directly on uart_rx,
// received strobes are collected by a monitor and matched against expectations.
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 1_843_200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_set = 3'd0;
    logic       uart_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         start;
        int         n;
        bit         chk_lat;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         at;
    } got_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] code;
        bit         stop_bad;
        int         skew;
        bit         noise;
        logic [7:0] exp_data;
        bit         exp_err;
    } vec_t;

    exp_t exp_q[$];
    got_t got_q[$];
    vec_t tbl[15];

    uart_byte_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_set   (baud_set),
        .uart_rx    (uart_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) got_q.push_back('{data_byte, frame_err, cyc});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: actual=%0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Clocks per oversample tick, straight from the baud table and divider formula.
    function automatic int tick_n(input logic [2:0] code);
        int baud;
        case (code)
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            default: baud = 9600;
        endcase
        return CLK_FREQ / (baud * 16);
    endfunction

    // Drives one 8N1 frame. skew is in parts per thousand of the bit period;
    // noise inverts the line around the middle vote sample of every data bit.
    task automatic send_frame(input logic [7:0] d, input logic [2:0] code, input bit stop_bad,
                              input int skew, input bit noise, input int idle_bits,
                              output int c0, output int n);
        int bitc;
        int t_prev;
        int t_next;
        logic [9:0] frame;
        n = tick_n(code);
        bitc = 16 * n;
        frame = {~stop_bad, d, 1'b0};
        baud_set = code;
        c0 = cyc;
        t_prev = 0;
        for (int b = 0; b < 10; b++) begin
            t_next = ((b + 1) * bitc * (1000 + skew) + 500) / 1000;
            uart_rx = frame[b];
            if (b == 3) baud_set = 3'($urandom);
            if (noise && b >= 1 && b <= 8) begin
                hold(8 * n - 2);
                uart_rx = ~frame[b];
                hold(5);
                uart_rx = frame[b];
                hold(t_next - t_prev - 8 * n - 3);
            end else begin
                hold(t_next - t_prev);
            end
            t_prev = t_next;
        end
        uart_rx = 1'b1;
        hold(idle_bits * bitc);
    endtask

    task automatic check_batch(input string tag);
        int waited;
        exp_t e;
        got_t g;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 4000) begin
            hold(1);
            waited++;
        end
        hold(40);
        check({tag, " strobe count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " data_byte"}, g.data, e.data);
            check({tag, " frame_err"}, g.err, e.err);
            // 9.5 bit periods plus 3..4 clk of input/output registering, +/-1 tick.
            if (e.chk_lat)
                check_range({tag, " latency"}, g.at - e.start,
                            152 * e.n + 3 - e.n, 152 * e.n + 4 + e.n);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int c0;
        int n;
        logic [7:0] d;
        logic [2:0] code;
        bit sb;
        int idle;

        tbl[0]  = '{8'haa, 3'd0, 1'b0,   0, 1'b0, 8'haa, 1'b0};
        tbl[1]  = '{8'hbb, 3'd0, 1'b0,   0, 1'b0, 8'hbb, 1'b0};
        tbl[2]  = '{8'h55, 3'd0, 1'b0,   0, 1'b0, 8'h55, 1'b0};
        for (int i = 0; i < 8; i++)
            tbl[3 + i] = '{8'h3c, 3'(i), 1'b0, 0, 1'b0, 8'h3c, 1'b0};
        tbl[11] = '{8'h81, 3'd0, 1'b1,   0, 1'b0, 8'h81, 1'b1};
        tbl[12] = '{8'hc3, 3'd0, 1'b0,  30, 1'b0, 8'hc3, 1'b0};
        tbl[13] = '{8'hc3, 3'd0, 1'b0, -30, 1'b0, 8'hc3, 1'b0};
        tbl[14] = '{8'hc3, 3'd0, 1'b0,   0, 1'b1, 8'hc3, 1'b0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_byte", data_byte, 8'h00);
        check("reset rx_done", rx_done, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset uart_state", uart_state, 1'b0);
        reset = 1'b0;
        hold(5);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            send_frame(tbl[i].data, tbl[i].code, tbl[i].stop_bad, tbl[i].skew,
                       tbl[i].noise, 1, c0, n);
            exp_q.push_back('{tbl[i].exp_data, tbl[i].exp_err, c0, n, (tbl[i].skew == 0)});
            check_batch($sformatf("vec%0d", i));
        end

        // Randomized frames against the reference model
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            code = 3'($urandom_range(0, 7));
            sb = ($urandom_range(0, 3) == 0);
            idle = sb ? $urandom_range(1, 2) : $urandom_range(0, 2);
            send_frame(d, code, sb, 0, 1'b0, idle, c0, n);
            exp_q.push_back('{d, sb, c0, n, 1'b1});
        end
        uart_rx = 1'b1;
        hold(200);
        check_batch("random");

        // Back-to-back frames with zero idle bits
        code = 3'($urandom_range(1, 4));
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            if (i == 2) d = d | 8'h01;
            send_frame(d, code, 1'b0, 0, 1'b0, (i == 2) ? 1 : 0, c0, n);
            exp_q.push_back('{d, 1'b0, c0, n, 1'b1});
        end
        check_batch("back2back");

        // Glitch: 3 clk low pulse at 9600
        baud_set = 3'd0;
        uart_rx = 1'b0;
        hold(3);
        uart_rx = 1'b1;
        hold(5);
        check("glitch uart_state busy", uart_state, 1'b1);
        hold(192);
        check("glitch uart_state idle", uart_state, 1'b0);
        check("glitch no strobe", got_q.size(), 0);
        got_q.delete();

        // Reset during bit 4 of 8'hff
        baud_set = 3'd0;
        uart_rx = 1'b0;
        hold(192);
        uart_rx = 1'b1;
        hold(4 * 192 + 96);
        check("pre-reset uart_state", uart_state, 1'b1);
        reset = 1'b1;
        #1;
        check("midreset data_byte", data_byte, 8'h00);
        check("midreset rx_done", rx_done, 1'b0);
        check("midreset frame_err", frame_err, 1'b0);
        check("midreset uart_state", uart_state, 1'b0);
        hold(3);
        reset = 1'b0;
        hold(6 * 192);
        check("midreset no strobe", got_q.size(), 0);
        got_q.delete();
        send_frame(8'h12, 3'd0, 1'b0, 0, 1'b0, 1, c0, n);
        exp_q.push_back('{8'h12, 1'b0, c0, n, 1'b1});
        check_batch("after reset");

        // Break: line held low for many frame times
        baud_set = 3'd0;
        c0 = cyc;
        uart_rx = 1'b0;
        hold(30 * 192);
        exp_q.push_back('{8'h00, 1'b1, c0, 12, 1'b1});
        check_batch("break");
        // Reset while the line is still low must not start a frame
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(12 * 192);
        check("low after reset uart_state", uart_state, 1'b0);
        check("low after reset no strobe", got_q.size(), 0);
        got_q.delete();
        uart_rx = 1'b1;
        hold(192);
        send_frame(8'h5a, 3'd4, 1'b0, 0, 1'b0, 1, c0, n);
        exp_q.push_back('{8'h5a, 1'b0, c0, n, 1'b1});
        check_batch("recovery");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
